// File: rtl/id_stage.sv
// RV32I decode stage: decodes the fetched word, reads the register file, and
// loads the ID/EX register. Stalls on load-use hazards and drops state on flush.
module id_stage #(
    parameter int                XLEN     = 32,
    parameter logic [XLEN-1:0]   RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            if_valid,
    output logic            if_ready,
    input  logic [31:0]     if_instr,
    input  logic [XLEN-1:0] if_pc,
    input  logic            flush,
    output logic [4:0]      rs1_select,
    output logic [4:0]      rs2_select,
    input  logic [31:0]     rs1_data,
    input  logic [31:0]     rs2_data,
    output logic            ex_valid,
    input  logic            ex_ready,
    output logic [XLEN-1:0] ex_pc,
    output logic [31:0]     ex_rs1_val,
    output logic [31:0]     ex_rs2_val,
    output logic [31:0]     ex_imm,
    output logic [4:0]      ex_rd,
    output logic [2:0]      ex_funct3,
    output logic [3:0]      ex_alu_op,
    output logic            ex_src_imm,
    output logic            ex_src_pc,
    output logic            ex_is_load,
    output logic            ex_is_store,
    output logic            ex_is_branch,
    output logic            ex_is_jal,
    output logic            ex_is_jalr,
    output logic            ex_reg_write,
    output logic            ex_illegal
);
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    localparam logic [3:0] ALU_ADD = 4'd0, ALU_SUB = 4'd1, ALU_SLL = 4'd2, ALU_SLT = 4'd3,
                           ALU_SLTU = 4'd4, ALU_XOR = 4'd5, ALU_SRL = 4'd6, ALU_SRA = 4'd7,
                           ALU_OR = 4'd8, ALU_AND = 4'd9, ALU_PASS_B = 4'd10;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [31:0]     rs1;
        logic [31:0]     rs2;
        logic [31:0]     imm;
        logic [4:0]      rd;
        logic [2:0]      funct3;
        logic [3:0]      alu_op;
        logic            src_imm;
        logic            src_pc;
        logic            is_load;
        logic            is_store;
        logic            is_branch;
        logic            is_jal;
        logic            is_jalr;
        logic            reg_write;
        logic            illegal;
    } ex_t;

    function automatic logic [3:0] alu_of(input logic [2:0] f3, input logic alt);
        case (f3)
            3'd0:    return alt ? ALU_SUB : ALU_ADD;
            3'd1:    return ALU_SLL;
            3'd2:    return ALU_SLT;
            3'd3:    return ALU_SLTU;
            3'd4:    return ALU_XOR;
            3'd5:    return alt ? ALU_SRA : ALU_SRL;
            3'd6:    return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction

    logic [6:0]  opcode;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
    logic        use_rs1, use_rs2;
    ex_t         dec;
    ex_t         ex_q;
    logic        ld_shadow_v;
    logic [4:0]  ld_shadow_rd;
    logic        stall, accept, handoff;

    assign opcode     = if_instr[6:0];
    assign f3         = if_instr[14:12];
    assign f7         = if_instr[31:25];
    assign rs1_select = if_instr[19:15];
    assign rs2_select = if_instr[24:20];

    assign imm_i = {{20{if_instr[31]}}, if_instr[31:20]};
    assign imm_s = {{20{if_instr[31]}}, if_instr[31:25], if_instr[11:7]};
    assign imm_b = {{19{if_instr[31]}}, if_instr[31], if_instr[7], if_instr[30:25], if_instr[11:8], 1'b0};
    assign imm_u = {if_instr[31:12], 12'b0};
    assign imm_j = {{11{if_instr[31]}}, if_instr[31], if_instr[19:12], if_instr[20], if_instr[30:21], 1'b0};

    always_comb begin
        dec        = '0;
        dec.pc     = if_pc;
        dec.rs1    = rs1_data;
        dec.rs2    = rs2_data;
        dec.rd     = if_instr[11:7];
        dec.funct3 = f3;
        dec.alu_op = ALU_ADD;
        use_rs1    = 1'b0;
        use_rs2    = 1'b0;
        case (opcode)
            OPC_OP: begin
                use_rs1       = 1'b1;
                use_rs2       = 1'b1;
                dec.reg_write = 1'b1;
                dec.alu_op    = alu_of(f3, if_instr[30]);
                // funct7 0100000 is only meaningful for SUB and SRA
                dec.illegal   = !(f7 == 7'h00 || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5)));
            end
            OPC_OP_IMM: begin
                use_rs1       = 1'b1;
                dec.reg_write = 1'b1;
                dec.src_imm   = 1'b1;
                dec.imm       = imm_i;
                dec.alu_op    = alu_of(f3, (f3 == 3'd5) && if_instr[30]);
                if (f3 == 3'd1)      dec.illegal = (f7 != 7'h00);
                else if (f3 == 3'd5) dec.illegal = !(f7 == 7'h00 || f7 == 7'h20);
            end
            OPC_LOAD: begin
                use_rs1       = 1'b1;
                dec.is_load   = 1'b1;
                dec.reg_write = 1'b1;
                dec.src_imm   = 1'b1;
                dec.imm       = imm_i;
            end
            OPC_STORE: begin
                use_rs1      = 1'b1;
                use_rs2      = 1'b1;
                dec.is_store = 1'b1;
                dec.src_imm  = 1'b1;
                dec.imm      = imm_s;
            end
            OPC_BRANCH: begin
                use_rs1       = 1'b1;
                use_rs2       = 1'b1;
                dec.is_branch = 1'b1;
                dec.alu_op    = ALU_SUB;
                dec.imm       = imm_b;
            end
            OPC_LUI: begin
                dec.reg_write = 1'b1;
                dec.src_imm   = 1'b1;
                dec.alu_op    = ALU_PASS_B;
                dec.imm       = imm_u;
            end
            OPC_AUIPC: begin
                dec.reg_write = 1'b1;
                dec.src_imm   = 1'b1;
                dec.src_pc    = 1'b1;
                dec.imm       = imm_u;
            end
            OPC_JAL: begin
                dec.reg_write = 1'b1;
                dec.src_pc    = 1'b1;
                dec.is_jal    = 1'b1;
                dec.imm       = imm_j;
            end
            OPC_JALR: begin
                use_rs1       = 1'b1;
                dec.reg_write = 1'b1;
                dec.src_imm   = 1'b1;
                dec.is_jalr   = 1'b1;
                dec.imm       = imm_i;
            end
            default: dec.illegal = 1'b1;
        endcase
        if (dec.illegal) begin
            dec.is_load   = 1'b0;
            dec.is_store  = 1'b0;
            dec.is_branch = 1'b0;
            dec.is_jal    = 1'b0;
            dec.is_jalr   = 1'b0;
            dec.reg_write = 1'b0;
        end
        if (dec.rd == 5'd0) dec.reg_write = 1'b0;
    end

    // A load's result is not forwardable while it sits in ID/EX or one cycle after
    always_comb begin
        stall = 1'b0;
        if (ex_valid && ex_q.is_load && ex_q.rd != 5'd0 &&
            ((use_rs1 && rs1_select == ex_q.rd) || (use_rs2 && rs2_select == ex_q.rd)))
            stall = 1'b1;
        if (ld_shadow_v &&
            ((use_rs1 && rs1_select == ld_shadow_rd) || (use_rs2 && rs2_select == ld_shadow_rd)))
            stall = 1'b1;
    end

    assign if_ready = !flush && !stall && (!ex_valid || ex_ready);
    assign accept   = if_valid && if_ready;
    assign handoff  = ex_valid && ex_ready && ex_q.is_load && (ex_q.rd != 5'd0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_valid     <= 1'b0;
            ex_q         <= '{pc: RESET_PC, default: '0};
            ld_shadow_v  <= 1'b0;
            ld_shadow_rd <= 5'd0;
        end else if (flush) begin
            ex_valid    <= 1'b0;
            ld_shadow_v <= 1'b0;
        end else begin
            ld_shadow_v <= handoff;
            if (handoff) ld_shadow_rd <= ex_q.rd;
            if (accept) begin
                ex_valid <= 1'b1;
                ex_q     <= dec;
            end else if (ex_valid && ex_ready) begin
                ex_valid <= 1'b0;
            end
        end
    end

    assign ex_pc        = ex_q.pc;
    assign ex_rs1_val   = ex_q.rs1;
    assign ex_rs2_val   = ex_q.rs2;
    assign ex_imm       = ex_q.imm;
    assign ex_rd        = ex_q.rd;
    assign ex_funct3    = ex_q.funct3;
    assign ex_alu_op    = ex_q.alu_op;
    assign ex_src_imm   = ex_q.src_imm;
    assign ex_src_pc    = ex_q.src_pc;
    assign ex_is_load   = ex_q.is_load;
    assign ex_is_store  = ex_q.is_store;
    assign ex_is_branch = ex_q.is_branch;
    assign ex_is_jal    = ex_q.is_jal;
    assign ex_is_jalr   = ex_q.is_jalr;
    assign ex_reg_write = ex_q.reg_write;
    assign ex_illegal   = ex_q.illegal;
endmodule

// File: tb/tb_id_stage.sv
// Bench for id_stage: directed scenarios plus random traffic, all checked every
// cycle against an instruction-level model of the decode stage.
module tb_id_stage;
    localparam logic [31:0] RPC = 32'h0000_0100;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        if_valid = 1'b0, flush = 1'b0, ex_ready = 1'b0;
    logic        if_ready;
    logic [31:0] if_instr = '0, if_pc = '0, rs1_data = '0, rs2_data = '0;
    logic [4:0]  rs1_select, rs2_select;
    logic        ex_valid;
    logic [31:0] ex_pc, ex_rs1_val, ex_rs2_val, ex_imm;
    logic [4:0]  ex_rd;
    logic [2:0]  ex_funct3;
    logic [3:0]  ex_alu_op;
    logic        ex_src_imm, ex_src_pc, ex_is_load, ex_is_store, ex_is_branch;
    logic        ex_is_jal, ex_is_jalr, ex_reg_write, ex_illegal;

    id_stage #(.XLEN(32), .RESET_PC(RPC)) dut (
        .clk(clk), .rst_n(rst_n), .if_valid(if_valid), .if_ready(if_ready),
        .if_instr(if_instr), .if_pc(if_pc), .flush(flush),
        .rs1_select(rs1_select), .rs2_select(rs2_select),
        .rs1_data(rs1_data), .rs2_data(rs2_data),
        .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_pc(ex_pc),
        .ex_rs1_val(ex_rs1_val), .ex_rs2_val(ex_rs2_val), .ex_imm(ex_imm),
        .ex_rd(ex_rd), .ex_funct3(ex_funct3), .ex_alu_op(ex_alu_op),
        .ex_src_imm(ex_src_imm), .ex_src_pc(ex_src_pc), .ex_is_load(ex_is_load),
        .ex_is_store(ex_is_store), .ex_is_branch(ex_is_branch), .ex_is_jal(ex_is_jal),
        .ex_is_jalr(ex_is_jalr), .ex_reg_write(ex_reg_write), .ex_illegal(ex_illegal)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] pc, r1, r2, imm;
        logic [4:0]  rd;
        logic [2:0]  f3;
        logic [3:0]  op;
        logic si, sp, ld, st, br, jal, jalr, rw, ill, u1, u2, hrd, hf3;
    } exp_t;

    int   vectors = 0, errors = 0;
    exp_t m = '0;
    logic m_valid = 1'b0, m_shv = 1'b0;
    logic [4:0] m_shrd = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Instruction-level meaning of each RV32I word
    function automatic exp_t model_dec(input logic [31:0] w);
        exp_t e = '0;
        logic [3:0] base [8] = '{4'd0, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd8, 4'd9};
        logic [6:0] opc = w[6:0];
        logic [2:0] fn3 = w[14:12];
        logic [6:0] fn7 = w[31:25];
        int sx = w[31] ? -1 : 0;
        e.rd = w[11:7];
        e.f3 = fn3;
        if (opc == 7'h33) begin
            e.u1 = 1; e.u2 = 1; e.hrd = 1; e.hf3 = 1; e.rw = 1;
            e.ill = !(fn7 == 0 || (fn7 == 7'h20 && (fn3 == 0 || fn3 == 5)));
            e.op = base[fn3] + ((fn7 == 7'h20) ? 4'd1 : 4'd0);
        end else if (opc == 7'h13) begin
            e.u1 = 1; e.hrd = 1; e.hf3 = 1; e.rw = 1; e.si = 1;
            e.imm = {{20{w[31]}}, w[31:20]};
            e.ill = (fn3 == 1 && fn7 != 0) || (fn3 == 5 && fn7 != 0 && fn7 != 7'h20);
            e.op = base[fn3] + ((fn3 == 5 && fn7 == 7'h20) ? 4'd1 : 4'd0);
        end else if (opc == 7'h03) begin
            e.u1 = 1; e.hrd = 1; e.hf3 = 1; e.rw = 1; e.si = 1; e.ld = 1;
            e.imm = {{20{w[31]}}, w[31:20]};
        end else if (opc == 7'h23) begin
            e.u1 = 1; e.u2 = 1; e.hf3 = 1; e.si = 1; e.st = 1;
            e.imm = {{20{w[31]}}, w[31:25], w[11:7]};
        end else if (opc == 7'h63) begin
            e.u1 = 1; e.u2 = 1; e.hf3 = 1; e.br = 1; e.op = 4'd1;
            e.imm = 32'(sx * 4096) + {w[7], w[30:25], w[11:8], 1'b0};
        end else if (opc == 7'h37) begin
            e.hrd = 1; e.rw = 1; e.si = 1; e.op = 4'd10; e.imm = w & 32'hFFFF_F000;
        end else if (opc == 7'h17) begin
            e.hrd = 1; e.rw = 1; e.si = 1; e.sp = 1; e.imm = w & 32'hFFFF_F000;
        end else if (opc == 7'h6F) begin
            e.hrd = 1; e.rw = 1; e.sp = 1; e.jal = 1;
            e.imm = 32'(sx * 1048576) + {w[19:12], w[20], w[30:21], 1'b0};
        end else if (opc == 7'h67) begin
            e.u1 = 1; e.hrd = 1; e.hf3 = 1; e.rw = 1; e.si = 1; e.jalr = 1;
            e.imm = {{20{w[31]}}, w[31:20]};
        end else begin
            e.ill = 1;
        end
        if (e.ill) begin
            e.ld = 0; e.st = 0; e.br = 0; e.jal = 0; e.jalr = 0; e.rw = 0;
        end
        if (e.rd == 0) e.rw = 0;
        return e;
    endfunction

    task automatic check_ex();
        chk("ex_valid", ex_valid, m_valid);
        chk("ld_shadow_v", dut.ld_shadow_v, m_shv);
        if (m_valid) begin
            chk("ex_pc", ex_pc, m.pc);
            chk("ex_rs1_val", ex_rs1_val, m.r1);
            chk("ex_rs2_val", ex_rs2_val, m.r2);
            chk("ex_illegal", ex_illegal, m.ill);
            chk("ex_reg_write", ex_reg_write, m.rw);
            chk("ex_flags", {ex_is_load, ex_is_store, ex_is_branch, ex_is_jal, ex_is_jalr},
                {m.ld, m.st, m.br, m.jal, m.jalr});
            if (m.hf3) chk("ex_funct3", ex_funct3, m.f3);
            if (!m.ill) begin
                chk("ex_imm", ex_imm, m.imm);
                chk("ex_alu_op", ex_alu_op, m.op);
                chk("ex_src", {ex_src_imm, ex_src_pc}, {m.si, m.sp});
                if (m.hrd) chk("ex_rd", ex_rd, m.rd);
            end
        end
    endtask

    // One clock: drive at negedge, check handshake, advance model, check ID/EX
    task automatic step(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                        input logic fl, input logic er, output logic rdy_seen,
                        output logic [4:0] rs1_seen);
        exp_t d;
        logic stall, rdy, acc, hand;
        @(negedge clk);
        if_valid = v; if_instr = ins; if_pc = pc; flush = fl; ex_ready = er;
        rs1_data = $urandom; rs2_data = $urandom;
        #1;
        d = model_dec(ins);
        d.pc = pc; d.r1 = rs1_data; d.r2 = rs2_data;
        stall = (m_valid && m.ld && m.rd != 0 &&
                 ((d.u1 && ins[19:15] == m.rd) || (d.u2 && ins[24:20] == m.rd))) ||
                (m_shv && ((d.u1 && ins[19:15] == m_shrd) || (d.u2 && ins[24:20] == m_shrd)));
        rdy = !fl && !stall && (!m_valid || er);
        rdy_seen = if_ready;
        rs1_seen = rs1_select;
        chk("if_ready", if_ready, rdy);
        chk("rs_select", {rs1_select, rs2_select}, {ins[19:15], ins[24:20]});
        acc  = v && rdy;
        hand = m_valid && er && m.ld && m.rd != 0;
        @(posedge clk);
        #1;
        if (fl) begin
            m_valid = 0; m_shv = 0;
        end else begin
            m_shv = hand;
            if (hand) m_shrd = m.rd;
            if (acc) begin
                m_valid = 1; m = d;
            end else if (m_valid && er) begin
                m_valid = 0;
            end
        end
        check_ex();
    endtask

    function automatic logic [31:0] rand_instr();
        logic [6:0] opcs [10] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h67, 7'h13};
        logic [31:0] w = $urandom;
        int k = $urandom_range(0, 10);
        if (k == 10) return w;
        w[6:0]   = opcs[k];
        w[11:7]  = 5'($urandom_range(0, 3));
        w[19:15] = 5'($urandom_range(0, 3));
        w[24:20] = 5'($urandom_range(0, 3));
        if ((k == 0 || k == 1 || k == 9) && $urandom_range(0, 4) != 0)
            w[31:25] = ($urandom_range(0, 1) != 0) ? 7'h20 : 7'h00;
        return w;
    endfunction

    logic       r;
    logic [4:0] s1;

    initial begin
        #12;
        chk("reset ex_valid", ex_valid, 0);
        chk("reset ex_pc", ex_pc, RPC);
        chk("reset ex_imm", ex_imm, 0);
        chk("reset ex_ctrl", {ex_alu_op, ex_reg_write, ex_is_load, ex_illegal}, 0);
        chk("reset ld_shadow_v", dut.ld_shadow_v, 0);
        @(negedge clk); rst_n = 1;

        // addi x1,x0,5
        step(1, 32'h00500093, 32'h200, 0, 1, r, s1);
        chk("addi ex_valid", ex_valid, 1);
        chk("addi ex_rd", ex_rd, 1);
        chk("addi ex_imm", ex_imm, 5);
        chk("addi ex_alu_op", ex_alu_op, 0);
        chk("addi src_imm/reg_write", {ex_src_imm, ex_reg_write}, 2'b11);

        // lw x2,0(x1) then add x3,x2,x1: two stall cycles
        step(1, 32'h0000A103, 32'h204, 0, 1, r, s1);
        step(1, 32'h001101B3, 32'h208, 0, 1, r, s1);
        chk("load-use stall in ID/EX", r, 0);
        step(1, 32'h001101B3, 32'h208, 0, 1, r, s1);
        chk("load-use stall in shadow", r, 0);
        step(1, 32'h001101B3, 32'h208, 0, 1, r, s1);
        chk("add accepted", r, 1);
        chk("add rs1_select", s1, 2);

        // sw x2,-4(x1)
        step(1, 32'hFE20AE23, 32'h20C, 0, 1, r, s1);
        chk("sw ex_imm", ex_imm, 32'hFFFFFFFC);
        chk("sw store/reg_write", {ex_is_store, ex_reg_write}, 2'b10);

        // lui x5,0x12345 held for 3 cycles
        step(1, 32'h123452B7, 32'h210, 0, 1, r, s1);
        for (int i = 0; i < 3; i++) begin
            step(1, 32'h00500093, 32'h214, 0, 0, r, s1);
            chk("lui hold ex_imm", ex_imm, 32'h12345000);
            chk("lui hold ex_alu_op", ex_alu_op, 10);
        end
        step(0, 32'h0, 32'h0, 0, 1, r, s1);

        // flush during load shadow, then an all-zero word
        step(1, 32'h0000A103, 32'h300, 0, 1, r, s1);
        step(0, 32'h0, 32'h0, 0, 1, r, s1);
        chk("shadow set", dut.ld_shadow_v, 1);
        step(1, 32'h001101B3, 32'h304, 1, 1, r, s1);
        chk("flush if_ready", r, 0);
        chk("flush ex_valid/shadow", {ex_valid, dut.ld_shadow_v}, 2'b00);
        step(1, 32'h00000000, 32'h308, 0, 1, r, s1);
        chk("zero word illegal", {ex_valid, ex_illegal, ex_reg_write}, 3'b110);

        // asynchronous reset while ID/EX holds a stalled instruction
        step(1, 32'h00500093, 32'h400, 0, 1, r, s1);
        step(0, 32'h0, 32'h0, 0, 0, r, s1);
        #2 rst_n = 0;
        #1;
        chk("async reset ex_valid", ex_valid, 0);
        chk("async reset ex_pc", ex_pc, RPC);
        m_valid = 0; m_shv = 0;
        @(negedge clk); rst_n = 1;
        step(1, 32'h00500093, 32'h404, 0, 0, r, s1);
        chk("if_ready after reset", r, 1);

        for (int i = 0; i < 3000; i++)
            step($urandom_range(0, 3) != 0, rand_instr(), $urandom & 32'hFFFF_FFFC,
                 $urandom_range(0, 19) == 0, $urandom_range(0, 9) < 7, r, s1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
